hazard_ctrl: RTL and testbench

Pipeline hazard controller driving the `flush`/stall inputs of the IF/ID and ID/EX registers and the freeze of all stages. It detects load-use hazards and taken control transfers resolved in EX. It also tracks data-cache miss waits with a handshake-driven FSM. Saturating event counters for cache/pipeline analysis are exported to the testbench and analysis logic.

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline/cache signal bundle between datapath and hazard controller
// Grouping of the ID/EX/MEM hazard inputs and the stall/flush/counter outputs.
interface hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       rs1endId;
   logic [4:0]       rs2endId;
   logic             useRs1Id;
   logic             useRs2Id;
   logic             lwEx;
   logic [4:0]       rdEx;
   logic             takenEx;
   logic             memReq;
   logic             memReady;
   logic             pcStall;
   logic             ifidStall;
   logic             ifidFlush;
   logic             idexFlush;
   logic             freeze;
   logic             missTimeout;
   logic [CNT_W-1:0] bubbleCnt;
   logic [CNT_W-1:0] flushCnt;
   logic [CNT_W-1:0] missCnt;
   logic [CNT_W-1:0] freezeCnt;

   modport master (
      output rs1endId, rs2endId, useRs1Id, useRs2Id, lwEx, rdEx, takenEx, memReq, memReady,
      input  pcStall, ifidStall, ifidFlush, idexFlush, freeze, missTimeout,
      input  bubbleCnt, flushCnt, missCnt, freezeCnt
   );

   modport slave (
      input  rs1endId, rs2endId, useRs1Id, useRs2Id, lwEx, rdEx, takenEx, memReq, memReady,
      output pcStall, ifidStall, ifidFlush, idexFlush, freeze, missTimeout,
      output bubbleCnt, flushCnt, missCnt, freezeCnt
   );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / control-transfer / d-cache-miss hazard controller
// Control outputs are combinational; miss FSM, timer and event counters are registered.
module hazard_ctrl #(
   parameter int CNT_W        = 32,
   parameter int MISS_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   hazard_ctrl_if.slave hc
);
   typedef enum logic {RUN, MISS} state_t;

   localparam int TW = $clog2(MISS_TIMEOUT + 1);

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic [CNT_W-1:0] freeze_q, freeze_d;

   logic mem_stall;
   logic miss_enter;
   logic load_use;
   logic sel_flush;
   logic sel_bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && (v != {CNT_W{1'b1}})) ? v + {{(CNT_W-1){1'b0}}, 1'b1} : v;
   endfunction

   always_comb begin
      state_d    = state_q;
      mem_stall  = 1'b0;
      miss_enter = 1'b0;
      case (state_q)
         RUN: begin
            if (hc.memReq && !hc.memReady) begin
               state_d    = MISS;
               miss_enter = 1'b1;
               mem_stall  = 1'b1;
            end
         end
         MISS: begin
            // memReq is not consulted here: the access is already committed.
            if (hc.memReady) state_d = RUN;
            else             mem_stall = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin
      load_use = hc.lwEx && (hc.rdEx != 5'd0) &&
                 ((hc.useRs1Id && (hc.rs1endId == hc.rdEx)) ||
                  (hc.useRs2Id && (hc.rs2endId == hc.rdEx)));
      sel_flush  = !mem_stall && hc.takenEx;
      sel_bubble = !mem_stall && !hc.takenEx && load_use;
   end

   assign hc.pcStall     = mem_stall || sel_bubble;
   assign hc.ifidStall   = mem_stall || sel_bubble;
   assign hc.ifidFlush   = sel_flush;
   assign hc.idexFlush   = sel_flush || sel_bubble;
   assign hc.freeze      = mem_stall;
   assign hc.missTimeout = timeout_q;
   assign hc.bubbleCnt   = bubble_q;
   assign hc.flushCnt    = flush_q;
   assign hc.missCnt     = miss_q;
   assign hc.freezeCnt   = freeze_q;

   always_comb begin
      timer_d   = timer_q;
      timeout_d = timeout_q;
      if (state_q == MISS) begin
         // Every cycle spent in MISS counts, including the one that sees memReady.
         if (timer_q == TW'(MISS_TIMEOUT - 1)) timeout_d = 1'b1;
         if (hc.memReady)                       timer_d = '0;
         else if (timer_q != TW'(MISS_TIMEOUT)) timer_d = timer_q + 1'b1;
      end
      bubble_d = sat_inc(bubble_q, sel_bubble);
      flush_d  = sat_inc(flush_q, sel_flush);
      miss_d   = sat_inc(miss_q, miss_enter);
      freeze_d = sat_inc(freeze_q, mem_stall);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         timer_q   <= '0;
         timeout_q <= 1'b0;
         bubble_q  <= '0;
         flush_q   <= '0;
         miss_q    <= '0;
         freeze_q  <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         timeout_q <= timeout_d;
         bubble_q  <= bubble_d;
         flush_q   <= flush_d;
         miss_q    <= miss_d;
         freeze_q  <= freeze_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Vector table plus hand sequences for miss, timeout, async reset and saturation.
module tb_hazard_ctrl;
   localparam int CNT_W = 4;

   logic clk;
   logic reset;

   hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

   hazard_ctrl #(.CNT_W(CNT_W), .MISS_TIMEOUT(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hc    (hif.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       lw;
      logic [4:0] rd;
      logic       tk;
      logic       mreq;
      logic       mrdy;
      logic [4:0] exp; // {pcStall, ifidStall, ifidFlush, idexFlush, freeze}
   } vec_t;

   vec_t sb_q[$];
   vec_t tbl[9];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(string n, logic [4:0] r1, logic u1, logic [4:0] r2, logic u2,
                               logic lw, logic [4:0] rd, logic tk, logic mq, logic mr,
                               logic [4:0] e);
      vec_t v;
      v.name = n; v.rs1 = r1; v.u1 = u1; v.rs2 = r2; v.u2 = u2; v.lw = lw;
      v.rd = rd; v.tk = tk; v.mreq = mq; v.mrdy = mr; v.exp = e;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] ctrl();
      return {hif.pcStall, hif.ifidStall, hif.ifidFlush, hif.idexFlush, hif.freeze};
   endfunction

   task automatic drive(vec_t v);
      hif.rs1endId = v.rs1; hif.useRs1Id = v.u1;
      hif.rs2endId = v.rs2; hif.useRs2Id = v.u2;
      hif.lwEx = v.lw; hif.rdEx = v.rd; hif.takenEx = v.tk;
      hif.memReq = v.mreq; hif.memReady = v.mrdy;
   endtask

   task automatic apply(vec_t v);
      vec_t e;
      drive(v);
      sb_q.push_back(v);
      @(negedge clk);
      e = sb_q.pop_front();
      chk(e.name, {27'd0, ctrl()}, {27'd0, e.exp});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      drive(mk("idle", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b00000));
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic chk_cnt(string tag, int b, int f, int m, int z);
      chk({tag, "_bubbleCnt"}, {28'd0, hif.bubbleCnt}, b);
      chk({tag, "_flushCnt"},  {28'd0, hif.flushCnt},  f);
      chk({tag, "_missCnt"},   {28'd0, hif.missCnt},   m);
      chk({tag, "_freezeCnt"}, {28'd0, hif.freezeCnt}, z);
   endtask

   initial begin
      tbl[0] = mk("t_idle",      5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b00000);
      tbl[1] = mk("t_lu_rs2",    5'd1, 0, 5'd5, 1, 1, 5'd5, 0, 0, 0, 5'b11010);
      tbl[2] = mk("t_rd0",       5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 0, 0, 5'b00000);
      tbl[3] = mk("t_nouse_rs2", 5'd5, 0, 5'd5, 0, 1, 5'd5, 0, 0, 0, 5'b00000);
      tbl[4] = mk("t_lu_rs1",    5'd9, 1, 5'd3, 1, 1, 5'd9, 0, 0, 0, 5'b11010);
      tbl[5] = mk("t_no_load",   5'd9, 1, 5'd9, 1, 0, 5'd9, 0, 0, 0, 5'b00000);
      tbl[6] = mk("t_tk_over_lu",5'd7, 1, 5'd0, 0, 1, 5'd7, 1, 0, 0, 5'b00110);
      tbl[7] = mk("t_taken",     5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 5'b00110);
      tbl[8] = mk("t_hit_lu",    5'd0, 0, 5'd4, 1, 1, 5'd4, 0, 1, 1, 5'b11010);

      clk = 1'b0;
      reset = 1'b0;
      idle_inputs();
      #1;
      chk("rst_ctrl", {27'd0, ctrl()}, 32'd0);
      chk("rst_timeout", {31'd0, hif.missTimeout}, 32'd0);
      chk_cnt("rst", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 9; i++) apply(tbl[i]);
      chk_cnt("tbl", 3, 2, 0, 0);

      // miss of 3 stalled cycles with a taken branch held in EX
      do_reset();
      apply(mk("m_c1", 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 5'b11001));
      apply(mk("m_c2", 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 5'b11001));
      apply(mk("m_c3", 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0, 5'b11001));
      apply(mk("m_c4", 5'd0, 0, 5'd0, 0, 0, 5'd0, 1, 0, 1, 5'b00110));
      apply(mk("m_c5", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b00000));
      chk_cnt("miss", 0, 1, 1, 3);
      chk("miss_timeout", {31'd0, hif.missTimeout}, 32'd0);

      // all three hazards at once: only the miss stall acts and nothing else counts
      do_reset();
      apply(mk("all3", 5'd6, 1, 5'd0, 0, 1, 5'd6, 1, 1, 0, 5'b11001));
      apply(mk("all3_end", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'b00000));
      chk_cnt("all3", 0, 0, 1, 1);

      // timeout: 1 RUN detect cycle then 5 MISS cycles with memReady low
      do_reset();
      apply(mk("to_c1", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 5'b11001));
      for (int i = 2; i <= 4; i++)
         apply(mk($sformatf("to_c%0d", i), 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11001));
      chk("to_before", {31'd0, hif.missTimeout}, 32'd0);
      apply(mk("to_c5", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11001));
      chk("to_set", {31'd0, hif.missTimeout}, 32'd1);
      apply(mk("to_c6", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11001));
      apply(mk("to_exit", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'b00000));
      chk("to_sticky", {31'd0, hif.missTimeout}, 32'd1);
      chk_cnt("to", 0, 0, 1, 6);

      // reset pulse in the middle of a MISS cycle
      apply(mk("rm_c1", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 5'b11001));
      apply(mk("rm_c2", 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'b11001));
      chk("rm_pre_freeze", {27'd0, ctrl()}, {27'd0, 5'b11001});
      #2;
      reset = 1'b0;
      #1;
      chk("rm_ctrl", {27'd0, ctrl()}, 32'd0);
      chk("rm_timeout", {31'd0, hif.missTimeout}, 32'd0);
      chk_cnt("rm", 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // bubble counter saturation at 15
      for (int i = 0; i < 15; i++)
         apply(mk("sat_lu", 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 0, 0, 5'b11010));
      chk("sat_15", {28'd0, hif.bubbleCnt}, 32'd15);
      for (int i = 0; i < 5; i++)
         apply(mk("sat_lu", 5'd3, 1, 5'd0, 0, 1, 5'd3, 0, 0, 0, 5'b11010));
      chk("sat_hold", {28'd0, hif.bubbleCnt}, 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
